load_store_unit: RTL and testbench

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/lsu_pkg.sv | 45 ++++
 rtl/load_store_unit_align.sv | 53 +++++
 rtl/load_store_unit.sv | 172 +++++++++++++++++
 tb/tb_load_store_unit.sv | 366 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Load/store unit shared types, funct3 codes and response codes.
// Also holds the request legality check used at issue.
package lsu_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } lsu_state_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [1:0] ERR_OK      = 2'b00;
  localparam logic [1:0] ERR_ALIGN   = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
  } bus_cmd_t;

  // funct3[1:0] is the access size; reserved encodings and
  // unsigned stores are rejected along with misalignment.
  function automatic logic req_bad(
    input logic       wr,
    input logic [2:0] f3,
    input logic [1:0] lo
  );
    logic illegal;
    logic mis;
    illegal = (f3 == 3'b011) || (f3 == 3'b110) ||
              (f3 == 3'b111) || (wr && f3[2]);
    mis = ((f3[1:0] == 2'b01) && lo[0]) ||
          ((f3[1:0] == 2'b10) && (lo != 2'b00));
    return illegal || mis;
  endfunction

endpackage

// File: rtl/load_store_unit_align.sv
// Store byte-lane steering and load extraction/extension.
// Purely combinational; no state lives here.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [1:0]  st_size,
  input  logic [1:0]  st_off,
  input  logic [31:0] st_data,
  output logic [3:0]  st_be,
  output logic [31:0] st_wdata,
  input  logic [2:0]  ld_funct3,
  input  logic [1:0]  ld_off,
  input  logic [31:0] ld_word,
  output logic [31:0] ld_data
);

  logic [31:0] ld_sh;

  // Replicate store data across lanes; enable only the target bytes.
  always_comb begin
    st_be    = '0;
    st_wdata = '0;
    unique case (1'b1)
      (st_size == 2'b00): begin
        st_be    = 4'b0001 << st_off;
        st_wdata = {4{st_data[7:0]}};
      end
      (st_size == 2'b01): begin
        st_be    = 4'b0011 << st_off;
        st_wdata = {2{st_data[15:0]}};
      end
      default: begin
        st_be    = 4'b1111;
        st_wdata = st_data;
      end
    endcase
  end

  // Align the addressed bytes to bit 0, then extend by funct3.
  always_comb begin
    ld_sh   = ld_word >> {ld_off, 3'b000};
    ld_data = '0;
    unique case (ld_funct3)
      F3_B:    ld_data = {{24{ld_sh[7]}}, ld_sh[7:0]};
      F3_H:    ld_data = {{16{ld_sh[15]}}, ld_sh[15:0]};
      F3_W:    ld_data = ld_sh;
      F3_BU:   ld_data = {24'h0, ld_sh[7:0]};
      F3_HU:   ld_data = {16'h0, ld_sh[15:0]};
      default: ld_data = '0;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// RV32I load/store unit: issue FSM, bus command register,
// transaction timeout and response registers.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        req_wr,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        stall,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic [1:0]  rsp_err,
  output logic        bus_req,
  input  logic        bus_gnt,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_rvalid,
  input  logic [31:0] bus_rdata
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  lsu_state_e  state;
  lsu_state_e  state_d;
  logic [CW-1:0] cnt;
  bus_cmd_t    cmd;
  logic [2:0]  ld_f3;
  logic [1:0]  ld_off;
  logic [1:0]  err_q;
  logic [31:0] rdata_q;

  logic        bad;
  logic        cnt_hit;
  logic        accept;
  logic        reject;
  logic        granted;
  logic        got_data;
  logic        expired;
  logic [3:0]  st_be;
  logic [31:0] st_wdata;
  logic [31:0] ld_data;

  assign bad     = req_bad(req_wr, req_funct3, req_addr[1:0]);
  assign cnt_hit = (cnt == CNT_LAST);

  lsu_align u_align (
    .st_size   (req_funct3[1:0]),
    .st_off    (req_addr[1:0]),
    .st_data   (req_wdata),
    .st_be     (st_be),
    .st_wdata  (st_wdata),
    .ld_funct3 (ld_f3),
    .ld_off    (ld_off),
    .ld_word   (bus_rdata),
    .ld_data   (ld_data)
  );

  assign bus_we    = cmd.we;
  assign bus_addr  = cmd.addr;
  assign bus_be    = cmd.be;
  assign bus_wdata = cmd.wdata;
  assign rsp_err   = err_q;
  assign rsp_rdata = rdata_q;

  // Next state, handshake outputs and one-cycle event strobes.
  always_comb begin
    state_d   = state;
    stall     = 1'b0;
    bus_req   = 1'b0;
    rsp_valid = 1'b0;
    accept    = 1'b0;
    reject    = 1'b0;
    granted   = 1'b0;
    got_data  = 1'b0;
    expired   = 1'b0;
    unique case (state)
      S_IDLE: begin
        stall = req_valid;
        if (req_valid) begin
          if (bad) begin
            reject  = 1'b1;
            state_d = S_DONE;
          end else begin
            accept  = 1'b1;
            state_d = S_REQ;
          end
        end
      end
      S_REQ: begin
        stall   = 1'b1;
        bus_req = 1'b1;
        if (bus_gnt) begin
          granted = 1'b1;
          state_d = cmd.we ? S_DONE : S_WAIT;
        end else if (cnt_hit) begin
          expired = 1'b1;
          state_d = S_DONE;
        end
      end
      S_WAIT: begin
        stall = 1'b1;
        if (bus_rvalid) begin
          got_data = 1'b1;
          state_d  = S_DONE;
        end else if (cnt_hit) begin
          expired = 1'b1;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        rsp_valid = 1'b1;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State, timeout counter, bus command and response registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= S_IDLE;
      cnt     <= '0;
      cmd     <= '0;
      ld_f3   <= '0;
      ld_off  <= '0;
      err_q   <= ERR_OK;
      rdata_q <= '0;
    end else begin
      state <= state_d;

      if (accept)
        cnt <= '0;
      else if (state == S_REQ || state == S_WAIT)
        cnt <= cnt + CW'(1);

      if (accept) begin
        cmd.we    <= req_wr;
        cmd.addr  <= {req_addr[31:2], 2'b00};
        cmd.be    <= st_be;
        cmd.wdata <= req_wr ? st_wdata : '0;
        ld_f3     <= req_funct3;
        ld_off    <= req_addr[1:0];
      end else if (granted || expired) begin
        cmd <= '0;
      end

      if (reject) begin
        err_q   <= ERR_ALIGN;
        rdata_q <= '0;
      end else if (expired) begin
        err_q   <= ERR_TIMEOUT;
        rdata_q <= '0;
      end else if (granted && cmd.we) begin
        err_q   <= ERR_OK;
        rdata_q <= '0;
      end else if (got_data) begin
        err_q   <= ERR_OK;
        rdata_q <= ld_data;
      end
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed self-checking bench for load_store_unit.
// Bus handshakes are driven cycle by cycle from the tasks.
module tb_load_store_unit;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_wr;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        stall;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_err;
  logic        bus_req;
  logic        bus_gnt;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic        bus_rvalid;
  logic [31:0] bus_rdata;

  int checks = 0;
  int errors = 0;

  int          ns;
  int          nr;
  logic [3:0]  be;
  logic [31:0] wd;
  logic [31:0] ad;
  logic        we;
  logic [1:0]  er;
  logic [31:0] rd;
  logic        dn;
  logic        rq;

  // {wr, funct3, addr} of requests that must take the error path
  logic [35:0] bad_tab [7] = '{
    {1'b0, 3'b010, 32'h0000_0102},
    {1'b1, 3'b001, 32'h0000_0101},
    {1'b0, 3'b001, 32'h0000_0103},
    {1'b0, 3'b011, 32'h0000_0100},
    {1'b1, 3'b100, 32'h0000_0100},
    {1'b0, 3'b110, 32'h0000_0100},
    {1'b0, 3'b111, 32'h0000_0100}
  };

  load_store_unit #(.TIMEOUT_CYCLES(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_wr     (req_wr),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .stall      (stall),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err),
    .bus_req    (bus_req),
    .bus_gnt    (bus_gnt),
    .bus_we     (bus_we),
    .bus_addr   (bus_addr),
    .bus_be     (bus_be),
    .bus_wdata  (bus_wdata),
    .bus_rvalid (bus_rvalid),
    .bus_rdata  (bus_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  // Runs one request from its IDLE cycle to one cycle past DONE.
  // Grant comes on REQ cycle gnt_wait+1; rvalid on the
  // rv_wait+1-th cycle after the grant (held through DONE).
  task automatic run_txn(
    input  logic        wr,
    input  logic [2:0]  f3,
    input  logic [31:0] addr,
    input  logic [31:0] wdat,
    input  int          gnt_wait,
    input  logic [31:0] rdat,
    input  int          rv_wait,
    output int          n_stall,
    output int          n_req,
    output logic [3:0]  be_o,
    output logic [31:0] wd_o,
    output logic [31:0] ad_o,
    output logic        we_o,
    output logic [1:0]  err_o,
    output logic [31:0] rd_o,
    output logic        done_o,
    output logic        req_done_o
  );
    int   reqs;
    int   posts;
    logic granted;
    logic gnow;
    n_stall = 0; n_req = 0; be_o = '0; wd_o = '0; ad_o = '0;
    we_o = 1'b0; err_o = 2'b11; rd_o = '1; done_o = 1'b0;
    req_done_o = 1'b1;
    reqs = 0; posts = 0; granted = 1'b0;
    req_valid  = 1'b1;
    req_wr     = wr;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wdat;
    bus_rdata  = rdat;
    for (int c = 0; c < 64 && !done_o; c++) begin
      bus_gnt    = bus_req && (reqs >= gnt_wait);
      bus_rvalid = granted && !wr && (posts >= rv_wait);
      #1;
      gnow = 1'b0;
      if (stall) n_stall++;
      if (bus_req) begin
        n_req++;
        reqs++;
      end
      if (bus_req && bus_gnt) begin
        be_o = bus_be; wd_o = bus_wdata;
        ad_o = bus_addr; we_o = bus_we;
        gnow = 1'b1;
      end
      if (granted) posts++;
      if (gnow) granted = 1'b1;
      if (rsp_valid) begin
        err_o = rsp_err; rd_o = rsp_rdata;
        req_done_o = bus_req; done_o = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    req_valid  = 1'b0;
    bus_gnt    = 1'b0;
    bus_rvalid = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b0;
    req_valid = 1'b0; req_wr = 1'b0; req_funct3 = '0;
    req_addr = '0; req_wdata = '0;
    bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_rdata = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({stall, rsp_valid, bus_req, bus_we} !== 4'b0000) begin
      errors++;
      $display("FAIL rst_ctl got %b want 0000",
               {stall, rsp_valid, bus_req, bus_we});
    end
    checks++;
    if ({bus_be, bus_addr, bus_wdata} !== 68'h0) begin
      errors++;
      $display("FAIL rst_bus got be=%h a=%h d=%h want 0",
               bus_be, bus_addr, bus_wdata);
    end
    checks++;
    if ({rsp_err, rsp_rdata} !== 34'h0) begin
      errors++;
      $display("FAIL rst_rsp got err=%b d=%h want 0", rsp_err, rsp_rdata);
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_load;
    run_txn(0, 3'b000, 32'h103, 0, 0, 32'h80FF1234, 0,
            ns, nr, be, wd, ad, we, er, rd, dn, rq);
    checks++;
    if ({dn, rd} !== {1'b1, 32'hFFFFFF80}) begin
      errors++; $display("FAIL lb_data got %h want ffffff80", rd);
    end
    checks++;
    if (ns !== 3) begin
      errors++; $display("FAIL lb_stall got %0d want 3", ns);
    end
    checks++;
    if ({er, we, ad} !== {2'b00, 1'b0, 32'h100}) begin
      errors++;
      $display("FAIL lb_bus got err=%b we=%b a=%h want 00 0 100", er, we, ad);
    end
    checks++;
    if ({rsp_valid, rsp_rdata} !== {1'b0, 32'hFFFFFF80}) begin
      errors++;
      $display("FAIL lb_hold got v=%b d=%h want 0 ffffff80",
               rsp_valid, rsp_rdata);
    end
    run_txn(0, 3'b100, 32'h103, 0, 0, 32'h80FF1234, 0,
            ns, nr, be, wd, ad, we, er, rd, dn, rq);
    checks++;
    if (rd !== 32'h00000080) begin
      errors++; $display("FAIL lbu_data got %h want 00000080", rd);
    end
    run_txn(0, 3'b001, 32'h102, 0, 1, 32'h80FF1234, 0,
            ns, nr, be, wd, ad, we, er, rd, dn, rq);
    checks++;
    if ({rd, ns} !== {32'hFFFF80FF, 32'd4}) begin
      errors++; $display("FAIL lh got d=%h st=%0d want ffff80ff 4", rd, ns);
    end
    run_txn(0, 3'b101, 32'h102, 0, 0, 32'h80FF1234, 0,
            ns, nr, be, wd, ad, we, er, rd, dn, rq);
    checks++;
    if (rd !== 32'h000080FF) begin
      errors++; $display("FAIL lhu_data got %h want 000080ff", rd);
    end
    run_txn(0, 3'b010, 32'h100, 0, 0, 32'h80FF1234, 2,
            ns, nr, be, wd, ad, we, er, rd, dn, rq);
    checks++;
    if ({rd, ns} !== {32'h80FF1234, 32'd5}) begin
      errors++; $display("FAIL lw got d=%h st=%0d want 80ff1234 5", rd, ns);
    end
  endtask

  task automatic test_store;
    run_txn(1, 3'b010, 32'h100, 32'hDEADBEEF, 2, 0, 0,
            ns, nr, be, wd, ad, we, er, rd, dn, rq);
    checks++;
    if ({be, wd, ad, we} !== {4'b1111, 32'hDEADBEEF, 32'h100, 1'b1}) begin
      errors++;
      $display("FAIL sw_bus got be=%b d=%h a=%h we=%b want 1111 deadbeef 100 1",
               be, wd, ad, we);
    end
    checks++;
    if ({ns, nr} !== {32'd4, 32'd3}) begin
      errors++; $display("FAIL sw_stall got st=%0d req=%0d want 4 3", ns, nr);
    end
    checks++;
    if ({dn, er, rd, rsp_valid} !== {1'b1, 2'b00, 32'h0, 1'b0}) begin
      errors++;
      $display("FAIL sw_rsp got done=%b err=%b d=%h v=%b want 1 00 0 0",
               dn, er, rd, rsp_valid);
    end
    run_txn(1, 3'b001, 32'h102, 32'h0000ABCD, 0, 0, 0,
            ns, nr, be, wd, ad, we, er, rd, dn, rq);
    checks++;
    if ({be, wd, ad, ns} !== {4'b1100, 32'hABCDABCD, 32'h100, 32'd2}) begin
      errors++;
      $display("FAIL sh got be=%b d=%h a=%h st=%0d want 1100 abcdabcd 100 2",
               be, wd, ad, ns);
    end
    run_txn(1, 3'b000, 32'h101, 32'h12345678, 0, 0, 0,
            ns, nr, be, wd, ad, we, er, rd, dn, rq);
    checks++;
    if ({be, wd} !== {4'b0010, 32'h78787878}) begin
      errors++;
      $display("FAIL sb got be=%b d=%h want 0010 78787878", be, wd);
    end
  endtask

  task automatic test_misaligned;
    run_txn(0, 3'b010, 32'h104, 0, 0, 32'h55AA55AA, 0,
            ns, nr, be, wd, ad, we, er, rd, dn, rq);
    for (int i = 0; i < 7; i++) begin
      run_txn(bad_tab[i][35], bad_tab[i][34:32], bad_tab[i][31:0],
              32'hFFFF_FFFF, 0, 32'h1234_5678, 0,
              ns, nr, be, wd, ad, we, er, rd, dn, rq);
      checks++;
      if ({dn, nr, ns, er, rd} !== {1'b1, 32'd0, 32'd1, 2'b01, 32'h0}) begin
        errors++;
        $display("FAIL bad%0d got done=%b req=%0d st=%0d err=%b d=%h want 1 0 1 01 0",
                 i, dn, nr, ns, er, rd);
      end
    end
  endtask

  task automatic test_timeout;
    run_txn(0, 3'b010, 32'h10C, 0, 0, 32'h0BADF00D, 0,
            ns, nr, be, wd, ad, we, er, rd, dn, rq);
    run_txn(0, 3'b010, 32'h100, 0, 1000, 32'h1111_1111, 0,
            ns, nr, be, wd, ad, we, er, rd, dn, rq);
    checks++;
    if ({dn, nr, ns} !== {1'b1, 32'd8, 32'd9}) begin
      errors++;
      $display("FAIL to_len got done=%b req=%0d st=%0d want 1 8 9", dn, nr, ns);
    end
    checks++;
    if ({er, rd, rq} !== {2'b10, 32'h0, 1'b0}) begin
      errors++;
      $display("FAIL to_rsp got err=%b d=%h req=%b want 10 0 0", er, rd, rq);
    end
  endtask

  task automatic test_back_to_back;
    run_txn(1, 3'b010, 32'h104, 32'h11223344, 0, 0, 0,
            ns, nr, be, wd, ad, we, er, rd, dn, rq);
    checks++;
    if ({ns, be, wd, ad} !== {32'd2, 4'b1111, 32'h11223344, 32'h104}) begin
      errors++;
      $display("FAIL b2b_sw got st=%0d be=%b d=%h a=%h want 2 1111 11223344 104",
               ns, be, wd, ad);
    end
    run_txn(0, 3'b010, 32'h108, 0, 0, 32'hCAFEF00D, 0,
            ns, nr, be, wd, ad, we, er, rd, dn, rq);
    checks++;
    if ({dn, ns, rd, ad} !== {1'b1, 32'd3, 32'hCAFEF00D, 32'h108}) begin
      errors++;
      $display("FAIL b2b_lw got done=%b st=%0d d=%h a=%h want 1 3 cafef00d 108",
               dn, ns, rd, ad);
    end
  endtask

  task automatic test_reset_mid;
    req_valid = 1'b1; req_wr = 1'b0; req_funct3 = 3'b010;
    req_addr = 32'h100; req_wdata = '0;
    bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_rdata = 32'h12345678;
    @(posedge clk);
    #1;
    bus_gnt = 1'b1;
    @(posedge clk);
    #1;
    bus_gnt = 1'b0;
    checks++;
    if ({stall, bus_req, rsp_rdata} !== {1'b1, 1'b0, 32'hCAFEF00D}) begin
      errors++;
      $display("FAIL rm_wait got st=%b req=%b d=%h want 1 0 cafef00d",
               stall, bus_req, rsp_rdata);
    end
    rst = 1'b0;
    req_valid = 1'b0;
    #1;
    checks++;
    if ({stall, rsp_valid, bus_req, bus_we, bus_be, bus_addr,
         bus_wdata, rsp_err, rsp_rdata} !== 106'h0) begin
      errors++;
      $display("FAIL rm_async got st=%b v=%b req=%b err=%b d=%h want all 0",
               stall, rsp_valid, bus_req, rsp_err, rsp_rdata);
    end
    @(posedge clk);
    #1;
    rst = 1'b1;
    bus_rvalid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      checks++;
      if ({stall, rsp_valid, bus_req, rsp_err, rsp_rdata} !== 37'h0) begin
        errors++;
        $display("FAIL rm_late%0d got st=%b v=%b req=%b err=%b d=%h want 0",
                 i, stall, rsp_valid, bus_req, rsp_err, rsp_rdata);
      end
    end
    bus_rvalid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_load();
    test_store();
    test_misaligned();
    test_timeout();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
